// File: rtl/sgmii_link_ctrl_pkg.sv
// Shared definitions for the SGMII link bring-up controller.
package sgmii_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_WAIT_SYNC = 3'd2,
    ST_QUALIFY   = 3'd3,
    ST_UP        = 3'd4,
    ST_DROP      = 3'd5
  } state_e;

  localparam logic [1:0] SPD_10M  = 2'b00;
  localparam logic [1:0] SPD_100M = 2'b01;
  localparam logic [1:0] SPD_1G   = 2'b10;

  localparam int LINK_STATUS_BIT = 0;
  localparam int LINK_SYNC_BIT   = 1;

  // The reserved speed code falls back to 1G.
  function automatic logic [1:0] speed_sel(input logic [1:0] req);
    case (req)
      SPD_10M:  return SPD_10M;
      SPD_100M: return SPD_100M;
      SPD_1G:   return SPD_1G;
      default:  return SPD_1G;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    if (a > b) return a;
    else return b;
  endfunction

endpackage

// File: rtl/sgmii_sync2.sv
// Parameterized-width two-flop synchronizer with async active-high clear.
module sgmii_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two back-to-back capture stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/sgmii_link_ctrl.sv
// SGMII PCS/PMA bring-up sequencer: reset hold, PLL lock wait, sync wait,
// debounced link qualification and teardown, with retry accounting.
module sgmii_link_ctrl
  import sgmii_link_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYC = 1250,
  parameter int LOCK_TMO_CYC = 125000,
  parameter int SYNC_TMO_CYC = 1250000,
  parameter int DEBOUNCE_CYC = 125
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FORCE_RESET,
  input  logic [1:0]  SPEED_REQ,
  input  logic        TX_PLL_LOCKED,
  input  logic        RX_PLL_LOCKED,
  input  logic [15:0] STATUS_VECTOR,
  output logic        SGMII_RESET,
  output logic [1:0]  SGMII_LINK,
  output logic        LINK_UP,
  output logic [7:0]  RETRY_CNT,
  output logic [2:0]  STATE
);

  localparam int MAX_CYC = max_int(max_int(RST_HOLD_CYC, LOCK_TMO_CYC),
                                   max_int(SYNC_TMO_CYC, DEBOUNCE_CYC));
  localparam int TMR_W = $clog2(MAX_CYC) + 1;

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TMO_CYC - 1);
  localparam logic [TMR_W-1:0] SYNC_LAST = TMR_W'(SYNC_TMO_CYC - 1);
  // The cycle that triggered QUALIFY/DROP is the first of the debounce run.
  localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEBOUNCE_CYC - 2);
  localparam logic [TMR_W-1:0] TMR_MAX   = {TMR_W{1'b1}};

  logic [3:0]       raw_s;
  logic [3:0]       sync_s;
  logic             locks_ok_s;
  logic             status_ok_s;
  logic             link_good_s;
  logic             unused_status_s;
  state_e           state_r;
  state_e           state_nx_s;
  logic             retry_inc_s;
  logic             restart_s;
  logic [TMR_W-1:0] timer_r;
  logic [7:0]       retry_cnt_r;
  logic             sgmii_reset_r;
  logic             link_up_r;
  logic [1:0]       sgmii_link_r;

  assign raw_s = {TX_PLL_LOCKED, RX_PLL_LOCKED,
                  STATUS_VECTOR[LINK_SYNC_BIT], STATUS_VECTOR[LINK_STATUS_BIT]};
  assign unused_status_s = ^STATUS_VECTOR[15:2];

  sgmii_sync2 #(.W(4)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (raw_s),
    .q   (sync_s)
  );

  assign locks_ok_s  = sync_s[3] & sync_s[2];
  assign status_ok_s = sync_s[1] & sync_s[0];
  assign link_good_s = locks_ok_s & status_ok_s;

  // Next-state selection; FORCE_RESET overrides every other transition.
  always_comb begin
    state_nx_s  = state_r;
    retry_inc_s = 1'b0;
    if (FORCE_RESET) begin
      state_nx_s = ST_HOLD;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (timer_r == HOLD_LAST) state_nx_s = ST_WAIT_LOCK;
          else state_nx_s = ST_HOLD;
        end
        ST_WAIT_LOCK: begin
          if (locks_ok_s) begin
            state_nx_s = ST_WAIT_SYNC;
          end else if (timer_r == LOCK_LAST) begin
            state_nx_s  = ST_HOLD;
            retry_inc_s = 1'b1;
          end else begin
            state_nx_s = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_SYNC: begin
          if (!locks_ok_s) begin
            state_nx_s = ST_HOLD;
          end else if (status_ok_s) begin
            state_nx_s = ST_QUALIFY;
          end else if (timer_r == SYNC_LAST) begin
            state_nx_s  = ST_HOLD;
            retry_inc_s = 1'b1;
          end else begin
            state_nx_s = ST_WAIT_SYNC;
          end
        end
        ST_QUALIFY: begin
          if (!link_good_s) state_nx_s = ST_WAIT_SYNC;
          else if (timer_r == DEB_LAST) state_nx_s = ST_UP;
          else state_nx_s = ST_QUALIFY;
        end
        ST_UP: begin
          if (!locks_ok_s) state_nx_s = ST_HOLD;
          else if (!link_good_s) state_nx_s = ST_DROP;
          else state_nx_s = ST_UP;
        end
        ST_DROP: begin
          if (link_good_s) state_nx_s = ST_UP;
          else if (timer_r == DEB_LAST) state_nx_s = ST_HOLD;
          else state_nx_s = ST_DROP;
        end
        default: begin
          state_nx_s = ST_HOLD;
        end
      endcase
    end
  end

  assign restart_s = FORCE_RESET | (state_nx_s != state_r);

  // State, shared timer, retry counter and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= ST_HOLD;
      timer_r       <= {TMR_W{1'b0}};
      retry_cnt_r   <= 8'd0;
      sgmii_reset_r <= 1'b1;
      link_up_r     <= 1'b0;
      sgmii_link_r  <= SPD_1G;
    end else begin
      state_r       <= state_nx_s;
      sgmii_reset_r <= (state_nx_s == ST_HOLD);
      link_up_r     <= (state_nx_s == ST_UP) || (state_nx_s == ST_DROP);
      if (restart_s) timer_r <= {TMR_W{1'b0}};
      else if (timer_r != TMR_MAX) timer_r <= timer_r + TMR_W'(1'b1);
      else timer_r <= timer_r;
      if (retry_inc_s && (retry_cnt_r != 8'hFF)) retry_cnt_r <= retry_cnt_r + 8'd1;
      else retry_cnt_r <= retry_cnt_r;
      // First HOLD cycle (timer at zero) is the only load point for the speed.
      if ((state_r == ST_HOLD) && (timer_r == {TMR_W{1'b0}})) sgmii_link_r <= speed_sel(SPEED_REQ);
      else sgmii_link_r <= sgmii_link_r;
    end
  end

  assign SGMII_RESET = sgmii_reset_r;
  assign SGMII_LINK  = sgmii_link_r;
  assign LINK_UP     = link_up_r;
  assign RETRY_CNT   = retry_cnt_r;
  assign STATE       = state_r;

endmodule

// File: tb/tb_sgmii_link_ctrl.sv
// Directed bench for sgmii_link_ctrl: a vector table for bring-up, debounce,
// force and sync timeout, then async reset, lock timeout and retry saturation.
module tb_sgmii_link_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FORCE_RESET;
  logic [1:0]  SPEED_REQ;
  logic        TX_PLL_LOCKED;
  logic        RX_PLL_LOCKED;
  logic [15:0] STATUS_VECTOR;
  logic        SGMII_RESET;
  logic [1:0]  SGMII_LINK;
  logic        LINK_UP;
  logic [7:0]  RETRY_CNT;
  logic [2:0]  STATE;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  sgmii_link_ctrl #(
    .RST_HOLD_CYC (8),
    .LOCK_TMO_CYC (20),
    .SYNC_TMO_CYC (40),
    .DEBOUNCE_CYC (4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .FORCE_RESET   (FORCE_RESET),
    .SPEED_REQ     (SPEED_REQ),
    .TX_PLL_LOCKED (TX_PLL_LOCKED),
    .RX_PLL_LOCKED (RX_PLL_LOCKED),
    .STATUS_VECTOR (STATUS_VECTOR),
    .SGMII_RESET   (SGMII_RESET),
    .SGMII_LINK    (SGMII_LINK),
    .LINK_UP       (LINK_UP),
    .RETRY_CNT     (RETRY_CNT),
    .STATE         (STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         at;
    logic       tx;
    logic       rx;
    logic [1:0] st;
    logic [1:0] spd;
    logic       frc;
    logic [2:0] e_state;
    logic       e_rst;
    logic       e_up;
    logic [1:0] e_link;
    logic [7:0] e_retry;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] s, input logic r,
                         input logic u, input logic [1:0] l, input logic [7:0] c);
    chk({nm, " state"}, {5'd0, STATE}, {5'd0, s});
    chk({nm, " sgmii_reset"}, {7'd0, SGMII_RESET}, {7'd0, r});
    chk({nm, " link_up"}, {7'd0, LINK_UP}, {7'd0, u});
    chk({nm, " sgmii_link"}, {6'd0, SGMII_LINK}, {6'd0, l});
    chk({nm, " retry_cnt"}, RETRY_CNT, c);
  endtask

  initial begin
    // Cycle numbers count clock edges after reset release; inputs change
    // at the cycle where a row starts, expectations hold at row.at.
    //            at   tx    rx    st     spd    frc   state rst   up    link   retry
    vecs.push_back('{0,   1'b0, 1'b0, 2'd0, 2'b01, 1'b0, 3'd0, 1'b1, 1'b0, 2'b10, 8'd0});
    vecs.push_back('{1,   1'b0, 1'b0, 2'd0, 2'b01, 1'b0, 3'd0, 1'b1, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{7,   1'b0, 1'b0, 2'd0, 2'b01, 1'b0, 3'd0, 1'b1, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{8,   1'b0, 1'b0, 2'd0, 2'b01, 1'b0, 3'd1, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{12,  1'b0, 1'b0, 2'd0, 2'b01, 1'b0, 3'd1, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{14,  1'b1, 1'b1, 2'd0, 2'b01, 1'b0, 3'd1, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{15,  1'b1, 1'b1, 2'd0, 2'b01, 1'b0, 3'd2, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{30,  1'b1, 1'b1, 2'd0, 2'b01, 1'b0, 3'd2, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{32,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd2, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{33,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd3, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{35,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd3, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{36,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd4, 1'b0, 1'b1, 2'b01, 8'd0});
    // 3-cycle status glitch: DROP but LINK_UP held
    vecs.push_back('{39,  1'b1, 1'b1, 2'd2, 2'b01, 1'b0, 3'd5, 1'b0, 1'b1, 2'b01, 8'd0});
    vecs.push_back('{41,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd5, 1'b0, 1'b1, 2'b01, 8'd0});
    vecs.push_back('{42,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd4, 1'b0, 1'b1, 2'b01, 8'd0});
    // 4-cycle status loss: teardown and 8-cycle reset pulse
    vecs.push_back('{46,  1'b1, 1'b1, 2'd2, 2'b01, 1'b0, 3'd5, 1'b0, 1'b1, 2'b01, 8'd0});
    vecs.push_back('{47,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd5, 1'b0, 1'b1, 2'b01, 8'd0});
    vecs.push_back('{48,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd0, 1'b1, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{55,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd0, 1'b1, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{56,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd1, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{57,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd2, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{60,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd3, 1'b0, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{61,  1'b1, 1'b1, 2'd3, 2'b01, 1'b0, 3'd4, 1'b0, 1'b1, 2'b01, 8'd0});
    // force while status goes bad, reserved speed request
    vecs.push_back('{62,  1'b1, 1'b1, 2'd2, 2'b11, 1'b1, 3'd0, 1'b1, 1'b0, 2'b01, 8'd0});
    vecs.push_back('{63,  1'b1, 1'b1, 2'd0, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 2'b10, 8'd0});
    vecs.push_back('{69,  1'b1, 1'b1, 2'd0, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 2'b10, 8'd0});
    vecs.push_back('{70,  1'b1, 1'b1, 2'd0, 2'b11, 1'b0, 3'd1, 1'b0, 1'b0, 2'b10, 8'd0});
    vecs.push_back('{71,  1'b1, 1'b1, 2'd0, 2'b11, 1'b0, 3'd2, 1'b0, 1'b0, 2'b10, 8'd0});
    // sync timeout after 40 cycles counts a retry
    vecs.push_back('{110, 1'b1, 1'b1, 2'd0, 2'b11, 1'b0, 3'd2, 1'b0, 1'b0, 2'b10, 8'd0});
    vecs.push_back('{111, 1'b1, 1'b1, 2'd0, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 2'b10, 8'd1});
    vecs.push_back('{119, 1'b1, 1'b1, 2'd0, 2'b11, 1'b0, 3'd1, 1'b0, 1'b0, 2'b10, 8'd1});
    vecs.push_back('{120, 1'b1, 1'b1, 2'd0, 2'b11, 1'b0, 3'd2, 1'b0, 1'b0, 2'b10, 8'd1});
    // lock loss in WAIT_SYNC: back to HOLD with no retry
    vecs.push_back('{122, 1'b0, 1'b1, 2'd0, 2'b11, 1'b0, 3'd2, 1'b0, 1'b0, 2'b10, 8'd1});
    vecs.push_back('{123, 1'b0, 1'b1, 2'd0, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 2'b10, 8'd1});

    RST = 1'b1;
    FORCE_RESET = 1'b0;
    SPEED_REQ = 2'b01;
    TX_PLL_LOCKED = 1'b0;
    RX_PLL_LOCKED = 1'b0;
    STATUS_VECTOR = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    chk_all("in reset", 3'd0, 1'b1, 1'b0, 2'b10, 8'd0);
    RST = 1'b0;
    cyc = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      TX_PLL_LOCKED = vecs[i].tx;
      RX_PLL_LOCKED = vecs[i].rx;
      STATUS_VECTOR = {14'd0, vecs[i].st};
      SPEED_REQ     = vecs[i].spd;
      FORCE_RESET   = vecs[i].frc;
      while (cyc < vecs[i].at) tick();
      chk_all($sformatf("row%0d", i), vecs[i].e_state, vecs[i].e_rst,
              vecs[i].e_up, vecs[i].e_link, vecs[i].e_retry);
    end

    // Async reset between edges while qualifying.
    TX_PLL_LOCKED = 1'b1;
    RX_PLL_LOCKED = 1'b1;
    STATUS_VECTOR = 16'h0003;
    SPEED_REQ     = 2'b00;
    FORCE_RESET   = 1'b0;
    for (int i = 0; i < 40 && STATE != 3'd3; i++) tick();
    chk("reach qualify", {5'd0, STATE}, 8'd3);
    TX_PLL_LOCKED = 1'b0;
    RX_PLL_LOCKED = 1'b0;
    STATUS_VECTOR = 16'h0000;
    #2;
    RST = 1'b1;
    #1;
    chk_all("async rst", 3'd0, 1'b1, 1'b0, 2'b10, 8'd0);
    #1;
    RST = 1'b0;
    cyc = 0;
    while (cyc < 7) tick();
    chk_all("post-rst hold", 3'd0, 1'b1, 1'b0, 2'b00, 8'd0);
    tick();
    chk_all("post-rst exit", 3'd1, 1'b0, 1'b0, 2'b00, 8'd0);

    // Lock timeout: HOLD every 28 cycles, retry saturates at 255.
    for (int k = 1; k <= 257; k++) begin
      while (cyc < 28 * k - 1) tick();
      chk($sformatf("tmo%0d wait_lock", k), {5'd0, STATE}, 8'd1);
      tick();
      chk($sformatf("tmo%0d hold", k), {5'd0, STATE}, 8'd0);
      chk($sformatf("tmo%0d retry", k), RETRY_CNT, (k > 255) ? 8'd255 : 8'(k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
